// File: rtl/traffic_pkg.sv
// Shared encodings and default timings for the intersection scheduler.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5,
        PED_WALK  = 3'd6
    } state_t;

    typedef enum logic {
        NS = 1'b0,
        EW = 1'b1
    } dir_t;

    localparam int DEF_GREEN_T  = 10;
    localparam int DEF_YELLOW_T = 4;
    localparam int DEF_ALLRED_T = 2;
    localparam int DEF_PED_T    = 6;
    localparam int DEF_TW       = 4;

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: clears on request, otherwise counts up and saturates at all-ones.
module phase_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [TW-1:0] limit,
    output logic          done
);

    logic [TW-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (count_q != {TW{1'b1}}) begin
            count_q <= count_q + TW'(1);
        end
    end

    // >= lets a resting green keep reporting done while the count sits saturated.
    assign done = (count_q >= limit);

endmodule

// File: rtl/intersection_scheduler.sv
// Two-approach intersection plus pedestrian crossing; FSM, ped latch and lamp decode.
// Optional emergency override enabled by defining EMERGENCY_PREEMPT_EN (adds port preempt).
module intersection_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_T  = DEF_GREEN_T,
    parameter int YELLOW_T = DEF_YELLOW_T,
    parameter int ALLRED_T = DEF_ALLRED_T,
    parameter int PED_T    = DEF_PED_T,
    parameter int TW       = DEF_TW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ns_car,
    input  logic       ew_car,
    input  logic       ped_req,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic       preempt,
`endif
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    localparam logic [TW-1:0] GREEN_L  = TW'(GREEN_T - 1);
    localparam logic [TW-1:0] YELLOW_L = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] ALLRED_L = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] PED_L    = TW'(PED_T - 1);

    state_t        state_q, state_d;
    dir_t          next_dir_q;
    logic          ped_pending_q, ped_pending_d;
    logic          rec_q;
    logic          pre;
    logic          clr, done;
    logic [TW-1:0] limit;

`ifdef EMERGENCY_PREEMPT_EN
    assign pre = preempt;
`else
    assign pre = 1'b0;
`endif

    always_comb begin
        limit = ALLRED_L;
        case (state_q)
            NS_GREEN, EW_GREEN:   limit = GREEN_L;
            NS_YELLOW, EW_YELLOW: limit = YELLOW_L;
            PED_WALK:             limit = PED_L;
            default:              limit = ALLRED_L;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            NS_GREEN:  if (pre || (done && (ew_car || ped_pending_q))) state_d = NS_YELLOW;
            NS_YELLOW: if (done) state_d = ALLRED_A;
            // Recovery from a preemption always restarts on NS, skipping any pending walk.
            ALLRED_A:  if (!pre && done)
                           state_d = rec_q ? NS_GREEN : (ped_pending_q ? PED_WALK : EW_GREEN);
            EW_GREEN:  if (pre || (done && (ns_car || ped_pending_q))) state_d = EW_YELLOW;
            EW_YELLOW: if (done) state_d = ALLRED_B;
            ALLRED_B:  if (pre) state_d = ALLRED_A;
                       else if (done) state_d = ped_pending_q ? PED_WALK : NS_GREEN;
            PED_WALK:  if (pre) state_d = ALLRED_A;
                       else if (done) state_d = (next_dir_q == NS) ? NS_GREEN : EW_GREEN;
            default:   state_d = ALLRED_B;
        endcase
    end

    // Holding ALLRED_A under preempt keeps the timer at zero so release gives a full clearance.
    assign clr = (state_d != state_q) || (pre && (state_q == ALLRED_A));

    always_comb begin
        ped_pending_d = ped_pending_q;
        if ((state_q == PED_WALK) || (state_d == PED_WALK)) begin
            ped_pending_d = 1'b0;
        end else if (ped_req) begin
            ped_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ALLRED_B;
            next_dir_q    <= NS;
            ped_pending_q <= 1'b0;
            rec_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ped_pending_q <= ped_pending_d;
            if (state_q == ALLRED_A) begin
                next_dir_q <= EW;
            end else if (state_q == ALLRED_B) begin
                next_dir_q <= NS;
            end
            if (pre) begin
                rec_q <= 1'b1;
            end else if ((state_q == ALLRED_A) && (state_d != ALLRED_A)) begin
                rec_q <= 1'b0;
            end
        end
    end

    phase_timer #(.TW(TW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .limit (limit),
        .done  (done)
    );

    assign ns_green    = (state_q == NS_GREEN);
    assign ns_yellow   = (state_q == NS_YELLOW);
    assign ns_red      = !(ns_green || ns_yellow);
    assign ew_green    = (state_q == EW_GREEN);
    assign ew_yellow   = (state_q == EW_YELLOW);
    assign ew_red      = !(ew_green || ew_yellow);
    assign walk        = (state_q == PED_WALK) && !pre;
    assign ped_pending = ped_pending_q;
    assign phase       = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler; preempt steps build only with EMERGENCY_PREEMPT_EN.
module tb_intersection_scheduler;

    localparam logic [2:0] P_NSG = 3'd0;
    localparam logic [2:0] P_NSY = 3'd1;
    localparam logic [2:0] P_ARA = 3'd2;
    localparam logic [2:0] P_EWG = 3'd3;
    localparam logic [2:0] P_EWY = 3'd4;
    localparam logic [2:0] P_ARB = 3'd5;
    localparam logic [2:0] P_PED = 3'd6;

    logic       clk, rst, ns_car, ew_car, ped_req;
    logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
    logic       walk, ped_pending;
    logic [2:0] phase;
`ifdef EMERGENCY_PREEMPT_EN
    logic       preempt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    intersection_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .ns_car      (ns_car),
        .ew_car      (ew_car),
        .ped_req     (ped_req),
`ifdef EMERGENCY_PREEMPT_EN
        .preempt     (preempt),
`endif
        .ns_red      (ns_red),
        .ns_yellow   (ns_yellow),
        .ns_green    (ns_green),
        .ew_red      (ew_red),
        .ew_yellow   (ew_yellow),
        .ew_green    (ew_green),
        .walk        (walk),
        .ped_pending (ped_pending),
        .phase       (phase)
    );

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected lamps {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g,walk} for each phase code
    function automatic logic [6:0] lamps_for(input logic [2:0] ph);
        case (ph)
            P_NSG:   return 7'b001_100_0;
            P_NSY:   return 7'b010_100_0;
            P_ARA:   return 7'b100_100_0;
            P_EWG:   return 7'b100_001_0;
            P_EWY:   return 7'b100_010_0;
            P_ARB:   return 7'b100_100_0;
            P_PED:   return 7'b100_100_1;
            default: return 7'b000_000_0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Check phase, lamps and ped latch once per cycle for n cycles, advancing after each.
    task automatic expect_run(input string tag, input logic [2:0] ph, input int n,
                              input logic pp);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d].phase", tag, i), {29'd0, phase}, {29'd0, ph});
            check($sformatf("%s[%0d].lamps", tag, i),
                  {25'd0, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk},
                  {25'd0, lamps_for(ph)});
            check($sformatf("%s[%0d].ped", tag, i), {31'd0, ped_pending}, {31'd0, pp});
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        ns_car  = 1'b0;
        ew_car  = 1'b0;
        ped_req = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
        preempt = 1'b0;
`endif
        step();
        expect_run("in_reset", P_ARB, 1, 1'b0);
        rst = 1'b0;

        // No demand: short all-red then NS green rests well past timer saturation
        expect_run("idle_arb", P_ARB, 2, 1'b0);
        expect_run("idle_nsg", P_NSG, 30, 1'b0);

        // EW demand from reset: full NS cycle into EW green, which then rests
        ew_car = 1'b1;
        do_reset();
        expect_run("ew_arb", P_ARB, 2, 1'b0);
        expect_run("ew_nsg", P_NSG, 10, 1'b0);
        expect_run("ew_nsy", P_NSY, 4, 1'b0);
        expect_run("ew_ara", P_ARA, 2, 1'b0);
        expect_run("ew_ewg", P_EWG, 12, 1'b0);

        // One-cycle ped pulse during NS green is served after ALLRED_A, then EW green
        do_reset();
        expect_run("pp_arb", P_ARB, 2, 1'b0);
        expect_run("pp_nsg0", P_NSG, 2, 1'b0);
        ped_req = 1'b1;
        expect_run("pp_nsg_pulse", P_NSG, 1, 1'b0);
        ped_req = 1'b0;
        expect_run("pp_nsg1", P_NSG, 7, 1'b1);
        expect_run("pp_nsy", P_NSY, 4, 1'b1);
        expect_run("pp_ara", P_ARA, 2, 1'b1);
        expect_run("pp_walk", P_PED, 6, 1'b0);

        // Ped held across walk entry from EW side: one walk, nothing re-latched
        ped_req = 1'b1;
        expect_run("ph_ewg0", P_EWG, 1, 1'b0);
        expect_run("ph_ewg1", P_EWG, 9, 1'b1);
        expect_run("ph_ewy", P_EWY, 4, 1'b1);
        expect_run("ph_arb", P_ARB, 2, 1'b1);
        expect_run("ph_walk_held", P_PED, 5, 1'b0);
        ped_req = 1'b0;
        expect_run("ph_walk_end", P_PED, 1, 1'b0);
        expect_run("ph_nsg", P_NSG, 10, 1'b0);
        expect_run("ph_nsy", P_NSY, 4, 1'b0);
        expect_run("ph_ara", P_ARA, 2, 1'b0);

        // Asynchronous reset in the middle of EW yellow
        ns_car = 1'b1;
        expect_run("rm_ewg", P_EWG, 10, 1'b0);
        expect_run("rm_ewy", P_EWY, 2, 1'b0);
        rst = 1'b1;
        #1;
        expect_run("rm_async", P_ARB, 1, 1'b0);
        rst = 1'b0;
        expect_run("rm_arb", P_ARB, 2, 1'b0);
        expect_run("rm_nsg", P_NSG, 10, 1'b0);
        expect_run("rm_nsy", P_NSY, 1, 1'b0);

`ifdef EMERGENCY_PREEMPT_EN
        // Preempt at NS green timer 3: immediate yellow, hold all-red, release to NS green
        ns_car = 1'b0;
        ew_car = 1'b0;
        do_reset();
        expect_run("pe_arb", P_ARB, 2, 1'b0);
        expect_run("pe_nsg0", P_NSG, 3, 1'b0);
        preempt = 1'b1;
        expect_run("pe_nsg_hit", P_NSG, 1, 1'b0);
        expect_run("pe_nsy", P_NSY, 4, 1'b0);
        expect_run("pe_hold", P_ARA, 5, 1'b0);
        preempt = 1'b0;
        expect_run("pe_release", P_ARA, 2, 1'b0);
        expect_run("pe_nsg", P_NSG, 5, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
